// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the 4:1 mux scan sequencer.
package mux_scan_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned WORD_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } state_t;

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Dwell counter: flags the last cycle of each channel's dwell window.
module mux_scan_dwell_cnt
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL = 2,
    parameter int unsigned CNT_W = 4
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic clr_in,
    input  logic en_in,
    output logic last_out
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt;

    assign last_out = en_in && (cnt == LAST);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt <= '0;
        end else if (clr_in || last_out) begin
            cnt <= '0;
        end else if (en_in) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans a 4:1 bit-select mux, assembles a 4-bit word and hands it off via valid/ready.
// Optional parity output enabled by defining MUX_SCAN_PARITY_EN.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL = 2,
    parameter int unsigned CNT_W = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic              cont_in,
    input  logic              y_in,
    output logic [SEL_W-1:0]  sel_out,
    output logic [WORD_W-1:0] word_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              busy_out
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic              parity_out
`endif
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    state_t state, state_next;

    logic              cnt_clr;
    logic              cnt_en;
    logic              last;
    logic              launch;
    logic              done;
    logic [WORD_W-1:0] shadow;
    logic [WORD_W-1:0] shadow_next;

    mux_scan_dwell_cnt #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell_cnt (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .clr_in   (cnt_clr),
        .en_in    (cnt_en),
        .last_out (last)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A continuous-mode handshake relaunches directly, so that edge is channel 0's first.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b1;
        cnt_en     = 1'b0;
        launch     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    state_next = SCAN;
                    launch     = 1'b1;
                end
            end
            SCAN: begin
                cnt_clr = 1'b0;
                cnt_en  = 1'b1;
                if (last && (sel_out == LAST_CH)) begin
                    state_next = HOLD;
                    done       = 1'b1;
                end
            end
            HOLD: begin
                if (ready_in) begin
                    if (cont_in) begin
                        state_next = SCAN;
                        launch     = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        shadow_next          = shadow;
        shadow_next[sel_out] = y_in;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sel_out   <= '0;
            shadow    <= '0;
            word_out  <= '0;
            valid_out <= 1'b0;
            busy_out  <= 1'b0;
        end else begin
            if (launch) begin
                sel_out <= '0;
            end else if (cnt_en && last) begin
                sel_out <= sel_out + 1'b1;
                shadow  <= shadow_next;
            end
            if (done) begin
                word_out <= shadow_next;
            end
            valid_out <= (state_next == HOLD);
            busy_out  <= (state_next != IDLE);
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            parity_out <= 1'b0;
        end else if (done) begin
            parity_out <= ^shadow_next;
        end
    end
`endif

endmodule
